// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the RV32I core: forms the writeback value
// (ALU, extracted load data, PC+4), flags faulting loads and counts retirements.
module mem_wb_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_m,
  input  logic                     RegWrite_m,
  input  logic [1:0]               ResultSrc_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] rd_m,
  input  logic [DATA_WIDTH-1:0]    ALUResult_m,
  input  logic [DATA_WIDTH-1:0]    ReadData_m,
  input  logic [DATA_WIDTH-1:0]    PCPlus4_m,
  output logic                     valid_w,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] rd_w,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     load_fault_w,
  output logic [31:0]              instret
);

  logic [1:0]            off;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] result;
  logic                  load_bad;
  logic                  fault;
  logic                  we_next;
  logic                  retire;

  assign off      = ALUResult_m[1:0];
  assign byte_sel = ReadData_m[{off, 3'b000} +: 8];
  assign half_sel = ReadData_m[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    load_bad  = 1'b0;
    case (funct3_m)
      3'b000: load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b001: begin
        load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        load_bad  = off[0];
      end
      3'b101: begin
        load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        load_bad  = off[0];
      end
      3'b010: begin
        load_data = ReadData_m;
        load_bad  = (off != 2'b00);
      end
      default: load_bad = 1'b1;
    endcase
  end

  // A faulting load never reaches the register file: data is zeroed and WE3 suppressed.
  always_comb begin
    fault = (ResultSrc_m == 2'b01) && load_bad;
    case (ResultSrc_m)
      2'b01:   result = load_data;
      2'b10:   result = PCPlus4_m;
      default: result = ALUResult_m;
    endcase
    if (fault) result = '0;
    we_next = valid_m && RegWrite_m && (rd_m != '0) && !fault;
    retire  = valid_m && !fault;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_w      <= 1'b0;
      WE3          <= 1'b0;
      rd_w         <= '0;
      WD3          <= '0;
      load_fault_w <= 1'b0;
      instret      <= '0;
    end else if (flush) begin
      valid_w      <= 1'b0;
      WE3          <= 1'b0;
      rd_w         <= '0;
      WD3          <= '0;
      load_fault_w <= 1'b0;
    end else if (!stall) begin
      valid_w      <= valid_m;
      WE3          <= we_next;
      rd_w         <= rd_m;
      WD3          <= result;
      load_fault_w <= valid_m && fault;
      if (retire) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes model-predicted W state,
// a negedge monitor pops and compares it, plus directed spot checks.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, valid_m = 1'b0, RegWrite_m = 1'b0;
  logic [1:0]  ResultSrc_m = '0;
  logic [2:0]  funct3_m = '0;
  logic [4:0]  rd_m = '0;
  logic [31:0] ALUResult_m = '0, ReadData_m = '0, PCPlus4_m = '0;
  logic        valid_w, WE3, load_fault_w;
  logic [4:0]  rd_w;
  logic [31:0] WD3, instret;

  mem_wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
    .RegWrite_m(RegWrite_m), .ResultSrc_m(ResultSrc_m), .funct3_m(funct3_m),
    .rd_m(rd_m), .ALUResult_m(ALUResult_m), .ReadData_m(ReadData_m),
    .PCPlus4_m(PCPlus4_m), .valid_w(valid_w), .WE3(WE3), .rd_w(rd_w),
    .WD3(WD3), .load_fault_w(load_fault_w), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid, we, lf;
    bit [4:0]  rd;
    bit [31:0] wd, cnt;
  } st_t;

  st_t m;
  st_t q[$];
  int  checks = 0;
  int  fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: architectural meaning of each load type, no datapath structure.
  task automatic model(input bit s, input bit f, input bit v, input bit rw, input bit [1:0] src,
                       input bit [2:0] f3, input bit [4:0] rdi, input bit [31:0] alu,
                       input bit [31:0] rdata, input bit [31:0] pc4);
    bit [31:0] val;
    bit        flt;
    int        o;
    o = int'(alu % 4);
    flt = 0;
    if (f) begin
      m.valid = 0; m.we = 0; m.lf = 0; m.rd = 0; m.wd = 0;
    end else if (!s) begin
      if (src == 2'd1) begin
        val = 0;
        case (f3)
          3'd0: val = 32'(int'(byte'(rdata >> (8 * o))));
          3'd4: val = (rdata >> (8 * o)) & 32'hFF;
          3'd1: begin flt = (o % 2) != 0; val = 32'(int'(shortint'(rdata >> (16 * (o / 2))))); end
          3'd5: begin flt = (o % 2) != 0; val = (rdata >> (16 * (o / 2))) & 32'hFFFF; end
          3'd2: begin flt = o != 0; val = rdata; end
          default: flt = 1;
        endcase
      end else if (src == 2'd2) val = pc4;
      else val = alu;
      if (flt) val = 0;
      m.valid = v;
      m.we    = v && rw && (rdi != 0) && !flt;
      m.rd    = rdi;
      m.wd    = val;
      m.lf    = v && flt;
      if (v && !flt) m.cnt = m.cnt + 1;
    end
  endtask

  task automatic step(input bit s, input bit f, input bit v, input bit rw, input bit [1:0] src,
                      input bit [2:0] f3, input bit [4:0] rdi, input bit [31:0] alu,
                      input bit [31:0] rdata, input bit [31:0] pc4);
    stall = s; flush = f; valid_m = v; RegWrite_m = rw; ResultSrc_m = src;
    funct3_m = f3; rd_m = rdi; ALUResult_m = alu; ReadData_m = rdata; PCPlus4_m = pc4;
    model(s, f, v, rw, src, f3, rdi, alu, rdata, pc4);
    @(posedge clk);
    #1;
    q.push_back(m);
  endtask

  initial begin : monitor
    st_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (valid_w !== e.valid || WE3 !== e.we || rd_w !== e.rd || WD3 !== e.wd ||
            load_fault_w !== e.lf || instret !== e.cnt) begin
          fails++;
          $display("FAIL scoreboard: got v=%0b we=%0b rd=%0d wd=%08h lf=%0b cnt=%08h expected v=%0b we=%0b rd=%0d wd=%08h lf=%0b cnt=%08h",
                   valid_w, WE3, rd_w, WD3, load_fault_w, instret,
                   e.valid, e.we, e.rd, e.wd, e.lf, e.cnt);
        end
      end
    end
  end

  localparam bit [31:0] RD = 32'h80F0_7F81;

  task automatic ld(input string name, input bit [2:0] f3, input bit [31:0] addr,
                    input bit [31:0] exp_wd, input bit exp_flt);
    bit [31:0] c0;
    c0 = m.cnt;
    step(0, 0, 1, 1, 2'd1, f3, 5'd7, addr, RD, 32'h0);
    chk({name, "_wd"}, WD3, exp_wd);
    chk({name, "_fault"}, {31'd0, load_fault_w}, {31'd0, exp_flt});
    chk({name, "_we"}, {31'd0, WE3}, {31'd0, !exp_flt});
    chk({name, "_cnt"}, instret, exp_flt ? c0 : c0 + 1);
  endtask

  initial begin : stim
    bit [31:0] frz_wd, frz_cnt;
    m = '{default: 0};

    // Reset held with inputs toggling
    repeat (3) begin
      @(posedge clk); #1;
      valid_m = 1; RegWrite_m = 1; rd_m = 5'($urandom_range(1, 31));
      ALUResult_m = $urandom; ReadData_m = $urandom;
      chk("rst_we", {31'd0, WE3}, 32'd0);
      chk("rst_wd", WD3, 32'd0);
      chk("rst_rd", {27'd0, rd_w}, 32'd0);
      chk("rst_cnt", instret, 32'd0);
      chk("rst_valid", {31'd0, valid_w}, 32'd0);
    end
    @(negedge clk); rst = 1;

    step(0, 0, 1, 1, 2'd0, 3'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    chk("first_we", {31'd0, WE3}, 32'd1);
    chk("first_rd", {27'd0, rd_w}, 32'd5);
    chk("first_wd", WD3, 32'h1234_5678);
    chk("first_cnt", instret, 32'd1);

    ld("lb0",  3'd0, 32'h1000, 32'hFFFF_FF81, 0);
    ld("lbu0", 3'd4, 32'h1000, 32'h0000_0081, 0);
    ld("lb1",  3'd0, 32'h1001, 32'h0000_007F, 0);
    ld("lh2",  3'd1, 32'h1002, 32'hFFFF_80F0, 0);
    ld("lhu2", 3'd5, 32'h1002, 32'h0000_80F0, 0);
    ld("lw0",  3'd2, 32'h1000, 32'h80F0_7F81, 0);
    ld("lw_mis", 3'd2, 32'h1002, 32'h0, 1);
    ld("lh_mis", 3'd1, 32'h1001, 32'h0, 1);
    ld("f3_011", 3'd3, 32'h1000, 32'h0, 1);

    frz_cnt = m.cnt;
    step(0, 0, 1, 1, 2'd2, 3'd0, 5'd0, 32'h55, 32'h0, 32'h104);
    chk("jal_x0_we", {31'd0, WE3}, 32'd0);
    chk("jal_x0_valid", {31'd0, valid_w}, 32'd1);
    chk("jal_x0_cnt", instret, frz_cnt + 1);
    step(0, 0, 1, 1, 2'd2, 3'd0, 5'd1, 32'h55, 32'h0, 32'h104);
    chk("jal_x1_we", {31'd0, WE3}, 32'd1);
    chk("jal_x1_wd", WD3, 32'h104);

    frz_wd = WD3; frz_cnt = instret;
    repeat (3) step(1, 0, 1, 1, 2'd0, 3'd0, 5'd9, $urandom, 32'h0, 32'h0);
    chk("stall_wd", WD3, 32'h104);
    chk("stall_cnt", instret, m.cnt);
    chk("stall_cnt_frozen", instret, frz_cnt);
    step(1, 1, 1, 1, 2'd0, 3'd0, 5'd9, 32'hABCD, 32'h0, 32'h0);
    chk("flush_valid", {31'd0, valid_w}, 32'd0);
    chk("flush_we", {31'd0, WE3}, 32'd0);

    repeat (400) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
           2'($urandom), 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
    end

    // Counter wrap
    @(negedge clk); #1;
    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    m.cnt = 32'hFFFF_FFFF;
    chk("preload", instret, 32'hFFFF_FFFF);
    step(0, 0, 1, 0, 2'd0, 3'd0, 5'd3, 32'h1, 32'h0, 32'h0);
    chk("wrap", instret, 32'h0);

    // Async reset mid-cycle with a write in flight
    step(0, 0, 1, 1, 2'd0, 3'd0, 5'd3, 32'hCAFE, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_we", {31'd0, WE3}, 32'd1);
    #1 rst = 0;
    #1;
    chk("async_we", {31'd0, WE3}, 32'd0);
    chk("async_wd", WD3, 32'd0);
    chk("async_cnt", instret, 32'd0);
    q.delete();
    m = '{default: 0};
    @(negedge clk); rst = 1;
    step(0, 0, 1, 1, 2'd0, 3'd0, 5'd4, 32'h77, 32'h0, 32'h0);
    chk("post_rst_cnt", instret, 32'd1);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
